// File: rtl/counter_pkg.sv
// counter_pkg: shared state/direction encodings and default width for the sweep controller
package counter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_e;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam int   DEFAULT_WIDTH = 5;
endpackage

// File: rtl/load_down_up_counter.sv
// load_down_up_counter: saturating counter, priority Load > Down > Up, no reset so it keeps its value
// Ports: CLK clock, IN load value, Load/Down/Up controls, Value count, High all ones, Low zero
module load_down_up_counter #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic [WIDTH-1:0] IN,
    input  logic             Load,
    input  logic             Up,
    input  logic             Down,
    output logic [WIDTH-1:0] Value,
    output logic             High,
    output logic             Low
);
    logic [WIDTH-1:0] value_q, value_d;
    assign High    = &value_q;
    assign Low     = value_q == '0;
    assign Value   = value_q;
    assign value_d = Load ? IN
                   : Down ? (Low ? value_q : value_q - WIDTH'(1))
                   : Up ? (High ? value_q : value_q + WIDTH'(1))
                   : value_q;
    always_ff @(posedge CLK)
        value_q <= value_d;
endmodule

// File: rtl/sweep_step_timer.sv
// sweep_step_timer: STEP_DIV prescaler, Tick high on the last count of each 0..STEP_DIV-1 period
// Ports: CLK clock, RST async active-low reset, Clear restarts the period at 0, Tick one-cycle step strobe
module sweep_step_timer #(
    parameter int STEP_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic Clear,
    output logic Tick
);
    localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign Tick  = cnt_q == CW'(STEP_DIV - 1);
    assign cnt_d = (Clear || Tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge CLK or negedge RST)
        if (!RST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: command-driven sequencer that loads a counter and steps it toward a stop value
// Ports: CLK/RST clock and async active-low reset; Cmd_* valid/ready sweep command; Abort cancel;
//        Busy/Done/Aborted/Err status; Cnt_IN/Cnt_Load/Cnt_Up/Cnt_Down counter controls;
//        Cnt_Value/Cnt_High/Cnt_Low counter feedback
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int STEP_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic [WIDTH-1:0] Cmd_Start,
    input  logic [WIDTH-1:0] Cmd_Stop,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic             Aborted,
    output logic             Err,
    output logic [WIDTH-1:0] Cnt_IN,
    output logic             Cnt_Load,
    output logic             Cnt_Up,
    output logic             Cnt_Down,
    input  logic [WIDTH-1:0] Cnt_Value,
    input  logic             Cnt_High,
    input  logic             Cnt_Low
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, stop_q, prev_q;
    logic             dir_q, err_q, aborted_q, stepped_q;
    logic             accept, abort_hit, at_stop, stall, tick, step;

    sweep_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .Clear(state_q != STEP),
        .Tick (tick)
    );

    assign accept    = state_q == IDLE && Cmd_Valid;
    assign abort_hit = Abort && (state_q == LOAD || state_q == STEP);
    assign at_stop   = Cnt_Value == stop_q;
    // a step issued last cycle must have moved the counter by exactly one
    assign stall     = stepped_q &&
                       Cnt_Value != (dir_q == DIR_UP ? prev_q + WIDTH'(1) : prev_q - WIDTH'(1));
    // never push the counter into its own saturation, and let abort/stall/stop suppress the step
    assign step      = state_q == STEP && !Abort && !stall && !at_stop && tick &&
                       (dir_q == DIR_UP ? !Cnt_High : !Cnt_Low);

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state_q   <= IDLE;
            start_q   <= '0;
            stop_q    <= '0;
            prev_q    <= '0;
            dir_q     <= DIR_DOWN;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            stepped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= abort_hit;
            stepped_q <= step;
            if (step) prev_q <= Cnt_Value;
            if (accept) begin
                start_q <= Cmd_Start;
                stop_q  <= Cmd_Stop;
                dir_q   <= Cmd_Stop > Cmd_Start ? DIR_UP : DIR_DOWN;
            end
            err_q <= accept ? 1'b0 : (state_q == STEP && !Abort && stall) ? 1'b1 : err_q;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = Abort ? IDLE : STEP;
            STEP:    state_d = (Abort || stall) ? IDLE : at_stop ? DONE : STEP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Cmd_Ready = state_q == IDLE;
        Busy      = state_q != IDLE;
        Done      = state_q == DONE;
        Aborted   = aborted_q;
        Err       = err_q;
        Cnt_IN    = start_q;
        Cnt_Load  = state_q == LOAD && !Abort;
        Cnt_Up    = step && dir_q == DIR_UP;
        Cnt_Down  = step && dir_q == DIR_DOWN;
    end
endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Command-driven sequencer for the 5-bit load/up/down counter.
- Accepts a sweep command (start value, stop value) over a valid/ready handshake.
- Loads the start value into the counter, then steps it one count at a time toward the stop value, at one step every STEP_DIV cycles.
- Reports completion, abort and stall error. Sits directly between a control host and one counter instance.

Parameters:
- WIDTH, 5, counter data width; must match the counter.
- STEP_DIV, 1, clock cycles per count step; legal range 1..16.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Cmd_Valid  in  1  command request.
- Cmd_Ready  out  1  controller idle; command accepted when Cmd_Valid and Cmd_Ready are both high at a rising edge.
- Cmd_Start  in  WIDTH  value to load.
- Cmd_Stop  in  WIDTH  target value.
- Abort  in  1  cancel the active sweep.
- Busy  out  1  sweep in progress.
- Done  out  1  one-cycle pulse on sweep completion.
- Aborted  out  1  one-cycle pulse on abort.
- Err  out  1  sticky stall error.
- Cnt_IN  out  WIDTH  drives the counter IN input.
- Cnt_Load  out  1  drives the counter Load input.
- Cnt_Up  out  1  drives the counter Up input.
- Cnt_Down  out  1  drives the counter Down input.
- Cnt_Value  in  WIDTH  counter output.
- Cnt_High  in  1  counter High flag (value = all ones).
- Cnt_Low  in  1  counter Low flag (value = 0).

Behaviour:
- Counter contract:
  - Registered on CLK.
  - Priority Load > Down > Up.
  - Saturates at 0 and at 2^WIDTH-1.
- Reset (RST=0), asynchronous, all registered state cleared:
  - State = IDLE.
  - Cnt_Load, Cnt_Up, Cnt_Down = 0; Cnt_IN = 0.
  - Done, Aborted, Err = 0.
  - Busy = 0; Cmd_Ready = 1.
- States: IDLE, LOAD, STEP, DONE.
- IDLE:
  - Cmd_Ready = 1.
  - On accept: latch start and stop; dir = UP if stop > start, else DOWN.
  - Clear Err and the step timer, then go to LOAD.
- LOAD, exactly 1 cycle:
  - Cnt_Load = 1, Cnt_IN = latched start.
  - Next state: STEP.
- STEP:
  - Each cycle, compare Cnt_Value with stop. If equal, no step is issued and the next state is DONE.
  - Otherwise the step timer counts 0..STEP_DIV-1. On the last count, assert Cnt_Up (dir UP) or Cnt_Down (dir DOWN) for exactly one cycle.
  - Cnt_Up is never asserted while Cnt_High=1. Cnt_Down is never asserted while Cnt_Low=1.
  - The Cnt_Up/Cnt_Down qualification is combinational on Cnt_Value, Cnt_High and Cnt_Low.
- Stall check:
  - In the cycle after a step, Cnt_Value must equal the previous value ±1.
  - On mismatch: Err = 1 (sticky until the next accepted command) and the next state is IDLE, with no Done pulse.
- DONE, 1 cycle: Done = 1, then IDLE.
- Busy = 1 in LOAD, STEP and DONE.
- Cnt_IN holds the latched start value after LOAD. Its value is don't-care while Cnt_Load = 0.
- Abort:
  - Sampled in LOAD or STEP.
  - Next state is IDLE; Aborted pulses 1 cycle.
  - Counter control outputs are deasserted in that same cycle. No Done pulse.
  - Abort in IDLE or DONE is ignored.
- Simultaneous events:
  - Abort beats reaching the stop value.
  - Cmd_Valid is ignored while not in IDLE; Cmd_Ready = 0 there.
- Latency: accept edge to Done pulse = 2 + |stop-start|*STEP_DIV + 1 cycles.
- start == stop: LOAD, one STEP cycle, then DONE. Done appears 3 cycles after accept.
- Mid-sweep reset: outputs clear immediately. The counter keeps its last value.

Decomposition:
- Shared package (counter_pkg):
  - State encoding: IDLE=2'd0, LOAD=2'd1, STEP=2'd2, DONE=2'd3.
  - Direction encoding: DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Default WIDTH.
- One sub-module, sweep_step_timer: STEP_DIV prescaler with clear input and a one-cycle tick output.
- The bench instantiates counter_sweep_ctrl together with load_down_up_counter, cross-wired.

Test Plan:
- Up sweep, start=3, stop=6, STEP_DIV=1 → Cnt_Load one cycle with Cnt_IN=3; Cnt_Value goes 3,4,5,6; Done pulses 6 cycles after accept; Err=0.
- Down sweep, start=2, stop=0 → Cnt_Down asserted twice; Cnt_Low=1 at completion; Cnt_Down never asserted while Cnt_Low=1; single Done pulse.
- Full sweep, start=0, stop=31, STEP_DIV=4 → exactly 31 steps, spaced 4 cycles apart; Cnt_High=1 at end; Done 127 cycles after accept.
- start=stop=17 → no Cnt_Up/Cnt_Down; Done 3 cycles after accept.
- Abort in STEP with Cnt_Value=10 (sweep 5→20) → Aborted pulse; controls deasserted in the same cycle; counter holds 10; no Done; Cmd_Ready=1 next cycle.
- Stall: force Cnt_Value constant during an up sweep → Err=1 after the first step; IDLE; next accepted command clears Err. Also: RST low mid-sweep → all outputs reset asynchronously.
